// File: rtl/icache_fetch_ctrl.sv
// Fetch-side icache controller: looks up one core fetch at a time, refills from the
// instruction memory bus on a miss, and returns the word (or an error) to the core.
module icache_fetch_ctrl #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ifu_req_valid,
    output logic             ifu_req_ready,
    input  logic [31:0]      ifu_req_pc,
    output logic             ifu_resp_valid,
    input  logic             ifu_resp_ready,
    output logic [31:0]      ifu_resp_data,
    output logic             ifu_resp_err,
    output logic [29:0]      ic_addr,
    output logic             ic_reqValid,
    output logic             ic_wen,
    output logic [31:0]      ic_wdata,
    input  logic             ic_is_hit,
    input  logic             ic_respValid,
    input  logic [31:0]      ic_rdata,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    input  logic             mem_resp_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [2:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1;
    // once valid is raised, it and its payload stay stable until that edge.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MREQ   = 3'd2,
        S_MWAIT  = 3'd3,
        S_FILL   = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    // The timer only has to reach TIMEOUT_CYC-1.
    localparam int              TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);

    state_e             state_q, state_d;
    logic [29:0]        pc_q, pc_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^ifu_req_pc[1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        data_d         = data_q;
        err_d          = err_q;
        timer_d        = timer_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        ifu_resp_err   = 1'b0;
        ic_addr        = '0;
        ic_reqValid    = 1'b0;
        ic_wen         = 1'b0;
        ic_wdata       = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;

        case (state_q)
            S_IDLE: begin
                ifu_req_ready = 1'b1;
                if (ifu_req_valid) begin
                    pc_d    = ifu_req_pc[31:2];
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                ic_addr     = pc_q;
                ic_reqValid = 1'b1;
                if (ic_is_hit) begin
                    data_d    = ic_rdata;
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d   = S_RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d    = S_MREQ;
                end
            end
            S_MREQ: begin
                ic_addr       = pc_q;
                mem_req_valid = 1'b1;
                mem_req_addr  = {pc_q, 2'b00};
                if (mem_req_ready) begin
                    timer_d = '0;
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                ic_addr = pc_q;
                timer_d = timer_q + TMR_W'(1);
                // A response arriving on the timeout cycle still wins.
                if (mem_resp_valid) begin
                    if (mem_resp_err) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end else begin
                        data_d  = mem_resp_data;
                        state_d = S_FILL;
                    end
                end else if (TMO_EN && (timer_q == TMR_LAST)) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = S_RESP;
                end
            end
            S_FILL: begin
                ic_addr  = pc_q;
                ic_wen   = 1'b1;
                ic_wdata = data_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                ic_addr        = pc_q;
                ifu_resp_valid = 1'b1;
                ifu_resp_data  = data_q;
                ifu_resp_err   = err_q;
                if (ifu_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign dbg_state = state_q;

    // The icache answers in the same cycle as the lookup strobe.
    a_ic_resp_with_lookup: assert property (@(posedge clock) disable iff (!reset_n)
        ic_reqValid |-> ic_respValid);

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl: small direct-mapped icache and memory models,
// a response/fill scoreboard fed by the driver and drained by independent monitors.
module tb_icache_fetch_ctrl;

  localparam int CNT_W = 32;
  localparam int TMO   = 4;

  logic        clock, reset_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;
  logic [29:0] ic_addr;
  logic        ic_reqValid, ic_wen;
  logic [31:0] ic_wdata;
  logic        ic_is_hit, ic_respValid;
  logic [31:0] ic_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic [2:0]  dbg_state;

  icache_fetch_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .ic_addr(ic_addr), .ic_reqValid(ic_reqValid), .ic_wen(ic_wen), .ic_wdata(ic_wdata),
    .ic_is_hit(ic_is_hit), .ic_respValid(ic_respValid), .ic_rdata(ic_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];        // {err, data}
  logic [61:0] fill_q[$];       // {word addr, data}
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[31:2], 2'b00} ^ 32'h1357_0000;
  endfunction

  // ---------------- icache model: 16 lines, direct mapped on word addr[3:0] ----------------
  logic [15:0] ic_v;
  logic [25:0] ic_tag [16];
  logic [31:0] ic_dat [16];
  assign ic_respValid = ic_reqValid;
  assign ic_is_hit    = ic_reqValid && ic_v[ic_addr[3:0]] && (ic_tag[ic_addr[3:0]] == ic_addr[29:4]);
  assign ic_rdata     = ic_dat[ic_addr[3:0]];
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ic_v <= '0;
    end else if (ic_wen) begin
      ic_v[ic_addr[3:0]]   <= 1'b1;
      ic_tag[ic_addr[3:0]] <= ic_addr[29:4];
      ic_dat[ic_addr[3:0]] <= ic_wdata;
    end
  end

  // ---------------- memory model ----------------
  int          mem_mode = 0;    // 0 ok, 1 error, 2 silent
  int          mem_wait = 0;
  int          mem_lat  = 1;
  bit          mem_late = 0;
  bit          mem_busy = 0;
  int          mem_acc_cyc = 0;
  int          mem_acc_cnt = 0;
  logic [31:0] exp_mem_addr = '0;

  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_req_valid && reset_n) begin
        mem_busy = 1;
        for (int i = 0; i < mem_wait; i++) begin
          chk("mem_req_held", {31'd0, mem_req_valid}, 64'd1);
          chk("mem_addr_stable", {32'd0, mem_req_addr}, {32'd0, exp_mem_addr});
          @(negedge clock);
        end
        chk("mem_addr", {32'd0, mem_req_addr}, {32'd0, exp_mem_addr});
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        mem_acc_cyc = cyc;
        mem_acc_cnt++;
        if (mem_mode != 2) begin
          for (int i = 1; i < mem_lat; i++) @(negedge clock);
          mem_resp_valid = 1'b1;
          mem_resp_err   = (mem_mode == 1);
          mem_resp_data  = mem_word(exp_mem_addr);
          @(negedge clock);
          mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_data = '0;
        end else if (mem_late) begin
          repeat (10) @(negedge clock);
          mem_resp_valid = 1'b1;
          mem_resp_data  = 32'hDEAD_BEEF;
          @(negedge clock);
          mem_resp_valid = 1'b0; mem_resp_data = '0;
        end
        mem_busy = 0;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    #1;
    if (ifu_resp_valid && ifu_resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'd0, ifu_resp_err, ifu_resp_data}, 64'h1_FFFF_FFFF_FFFF);
      end else begin
        chk("resp", {31'd0, ifu_resp_err, ifu_resp_data}, {31'd0, exp_q.pop_front()});
      end
    end
    if (ic_wen) begin
      chk("fill_no_lookup", {63'd0, ic_reqValid}, 64'd0);
      if (fill_q.size() == 0) begin
        chk("unexpected_fill", {2'd0, ic_addr, ic_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("fill", {2'd0, ic_addr, ic_wdata}, {2'd0, fill_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_fetch(input logic [31:0] pc, input int mode, input int wait_c,
                          input int lat, input bit exp_hit, input int hold, input bit late);
    logic [31:0] w;
    logic [32:0] e;
    int acc;
    int n;
    bit got;
    w = mem_word(pc);
    if (exp_hit) exp_hits++; else exp_misses++;
    e = (!exp_hit && mode != 0) ? {1'b1, 32'h0} : {1'b0, w};
    exp_q.push_back(e);
    if (!exp_hit && mode == 0) fill_q.push_back({pc[31:2], w});
    mem_mode = mode; mem_wait = wait_c; mem_lat = lat; mem_late = late;
    exp_mem_addr = {pc[31:2], 2'b00};

    @(negedge clock);
    ifu_req_valid = 1'b1;
    ifu_req_pc    = pc;
    n = 0;
    while (!ifu_req_ready && n < 50) begin @(negedge clock); n++; end
    chk("req_ready", {63'd0, ifu_req_ready}, 64'd1);
    @(posedge clock);
    @(negedge clock);
    acc = cyc;
    ifu_req_valid = 1'b0;
    ifu_req_pc    = $urandom;

    got = 0; n = 0;
    while (!got && n < 100) begin
      if (ifu_resp_valid) got = 1;
      else begin @(negedge clock); n++; end
    end
    chk("resp_seen", {63'd0, got}, 64'd1);
    if (exp_hit) chk("hit_latency", 64'(cyc - acc + 1), 64'd2);
    // Timeout fires after TMO cycles spent waiting for the memory.
    if (mode == 2) chk("timeout_cycles", 64'(cyc - mem_acc_cyc), 64'(TMO));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {63'd0, ifu_resp_valid}, 64'd1);
      chk("hold_req_ready", {63'd0, ifu_req_ready}, 64'd0);
      chk("hold_payload", {31'd0, ifu_resp_err, ifu_resp_data}, {31'd0, e});
      @(negedge clock);
    end
    ifu_resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ifu_resp_ready = 1'b0;

    n = 0;
    while (mem_busy && n < 50) begin @(negedge clock); n++; end
    chk("mem_idle", {63'd0, mem_busy}, 64'd0);
    chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
    chk("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int start_acc;
    reset_n = 1'b0; ifu_req_valid = 1'b0; ifu_req_pc = '0; ifu_resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", {63'd0, ifu_req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, ifu_resp_valid}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_ic_wen", {63'd0, ic_wen}, 64'd0);
    chk("rst_ic_addr", {34'd0, ic_addr}, 64'd0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // cold miss then hit
    do_fetch(32'h100, 0, 0, 3, 0, 0, 0);
    do_fetch(32'h100, 0, 0, 3, 1, 0, 0);
    // conflicts on icache index 0
    do_fetch(32'h040, 0, 1, 2, 0, 0, 0);
    do_fetch(32'h080, 0, 0, 1, 0, 0, 0);
    do_fetch(32'h040, 0, 0, 2, 0, 0, 0);
    // bus error: no fill, refetch misses, then hits
    do_fetch(32'h200, 1, 0, 2, 0, 0, 0);
    do_fetch(32'h200, 0, 2, 2, 0, 0, 0);
    do_fetch(32'h200, 0, 0, 1, 1, 0, 0);
    // timeout with a late response, then response on the timeout cycle
    do_fetch(32'h304, 2, 0, 1, 0, 0, 1);
    do_fetch(32'h304, 0, 0, TMO, 0, 0, 0);
    do_fetch(32'h304, 0, 0, 1, 1, 0, 0);
    // backpressure on hit and miss
    do_fetch(32'h304, 0, 0, 1, 1, 5, 0);
    do_fetch(32'h044, 0, 1, 3, 0, 5, 0);

    // reset while waiting for memory
    mem_mode = 2; mem_late = 0; mem_wait = 0; exp_mem_addr = 32'h400;
    start_acc = mem_acc_cnt;
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h400;
    @(negedge clock);
    ifu_req_valid = 1'b0;
    n = 0;
    while (mem_acc_cnt == start_acc && n < 50) begin @(negedge clock); n++; end
    chk("mem_accept_before_reset", 64'(mem_acc_cnt - start_acc), 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req_ready", {63'd0, ifu_req_ready}, 64'd1);
    chk("async_rst_resp_valid", {63'd0, ifu_resp_valid}, 64'd0);
    chk("async_rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
    @(negedge clock);
    chk("rst_idle_mem_req", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_idle_wen", {63'd0, ic_wen}, 64'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_rst_idle", {63'd0, ifu_req_ready}, 64'd1);

    chk("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("fill_queue_empty", 64'(fill_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
